sram_mem_stage: RTL and testbench

Memory stage that consumes the execute stage's `ALU_result`, `reg2`, `mem_read`, `mem_write`, `WB_Enable` and `RD` outputs and services loads and stores against an external 16-bit asynchronous SRAM. Each 32-bit access is split into two halfword phases with programmable wait states. While an access is in flight, `freeze` stalls the upstream pipeline registers. The block feeds the MEM/WB pipeline register.

---
 rtl/sram_mem_stage.sv | 139 +++++++++++++
 tb/tb_sram_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_mem_stage                                                  |
// | Purpose  : Pipeline memory stage; 32-bit loads/stores split into two       |
// |            16-bit SRAM phases with wait states, stalling upstream.         |
// |            Optional access counters via SRAM_MEM_STAGE_STATS_EN.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_mem_stage #(
    parameter int          WAIT_CYCLES = 1,
    parameter int unsigned DATA_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_Enable_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  RD_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Val_Rm_in,
    output logic        WB_Enable,
    output logic        mem_read,
    output logic [3:0]  RD,
    output logic [31:0] ALU_result,
    output logic [31:0] mem_data,
    output logic        freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N
`ifdef SRAM_MEM_STAGE_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam logic [2:0] c_wait = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        w_req;
    logic        w_is_wr;
    logic        w_is_rd;
    logic        w_terminal;
    logic        w_we_n_cont;
    logic [31:0] w_off;
    logic        w_unused_off;

    assign w_req        = mem_read_in | mem_write_in;
    assign w_is_wr      = mem_write_in;
    assign w_is_rd      = mem_read_in & ~mem_write_in;
    assign w_off        = ALU_result_in - DATA_BASE;
    assign w_unused_off = ^{w_off[31:19], w_off[1:0]};
    assign w_terminal   = (r_cnt == c_wait);
    // Strobe stays low until the phase's last cycle so the rising edge sees stable addr/data.
    assign w_we_n_cont  = ~(w_is_wr && ((r_cnt + 3'd1) < c_wait));

    assign freeze     = w_req & (r_state != S_DONE);
    assign WB_Enable  = WB_Enable_in & ~freeze;
    assign mem_read   = mem_read_in;
    assign RD         = RD_in;
    assign ALU_result = ALU_result_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            mem_data    <= 32'd0;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_DQ_out <= 16'd0;
            SRAM_ADDR   <= 18'd0;
`ifdef SRAM_MEM_STAGE_STATS_EN
            rd_count    <= 16'd0;
            wr_count    <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state     <= S_LO;
                        r_cnt       <= 3'd0;
                        SRAM_ADDR   <= {w_off[18:2], 1'b0};
                        SRAM_DQ_out <= Val_Rm_in[15:0];
                        SRAM_WE_N   <= ~w_is_wr;
                        SRAM_DQ_oe  <= w_is_wr;
                    end
                end
                S_LO: begin
                    if (w_terminal) begin
                        r_state     <= S_HI;
                        r_cnt       <= 3'd0;
                        if (w_is_rd) mem_data[15:0] <= SRAM_DQ_in;
                        SRAM_ADDR   <= {w_off[18:2], 1'b1};
                        SRAM_DQ_out <= Val_Rm_in[31:16];
                        SRAM_WE_N   <= ~w_is_wr;
                        SRAM_DQ_oe  <= w_is_wr;
                    end else begin
                        r_cnt     <= r_cnt + 3'd1;
                        SRAM_WE_N <= w_we_n_cont;
                    end
                end
                S_HI: begin
                    if (w_terminal) begin
                        r_state    <= S_DONE;
                        r_cnt      <= 3'd0;
                        if (w_is_rd) mem_data[31:16] <= SRAM_DQ_in;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_DQ_oe <= 1'b0;
`ifdef SRAM_MEM_STAGE_STATS_EN
                        if (w_is_rd) rd_count <= rd_count + 16'd1;
                        if (w_is_wr) wr_count <= wr_count + 16'd1;
`endif
                    end else begin
                        r_cnt     <= r_cnt + 3'd1;
                        SRAM_WE_N <= w_we_n_cont;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_mem_stage                                               |
// | Purpose  : Randomized self-checking bench with SRAM and word-level model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sram_mem_stage;

    localparam int          W    = 1;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WB_Enable_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [3:0]  RD_in = 4'd0;
    logic [31:0] ALU_result_in = 32'd0, Val_Rm_in = 32'd0;
    logic        WB_Enable, mem_read, freeze, SRAM_DQ_oe, SRAM_WE_N;
    logic [3:0]  RD;
    logic [31:0] ALU_result, mem_data;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
`ifdef SRAM_MEM_STAGE_STATS_EN
    logic [15:0] rd_count, wr_count;
`endif

    sram_mem_stage #(.WAIT_CYCLES(W), .DATA_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .WB_Enable_in(WB_Enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .RD_in(RD_in), .ALU_result_in(ALU_result_in), .Val_Rm_in(Val_Rm_in),
        .WB_Enable(WB_Enable), .mem_read(mem_read), .RD(RD), .ALU_result(ALU_result),
        .mem_data(mem_data), .freeze(freeze), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N)
`ifdef SRAM_MEM_STAGE_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: combinational read, write while the strobe is low.
    logic [15:0] sram [0:262143];
    assign SRAM_DQ_in = sram[SRAM_ADDR];
    always @(negedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR] <= SRAM_DQ_out;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_mem_data = 32'd0;
    int          ref_rd = 0;
    int          ref_wr = 0;

    function automatic logic [31:0] make_addr(input int idx);
        logic [31:0] r;
        logic [31:0] off;
        logic [3:0]  i4;
        r   = $urandom();
        i4  = 4'(idx);
        off = {r[31:19], 13'd0, i4, r[1:0]};
        return off + BASE;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        int          word, frz, we_lo, we_hi, pc;
        logic        half, exp_frz;
        logic [15:0] exp_dq;
        off  = addr - BASE;
        word = int'(off[18:2]);
        frz = 0; we_lo = 0; we_hi = 0;
        RD_in = 4'($urandom()); WB_Enable_in = wb;
        mem_read_in = rd; mem_write_in = wr;
        ALU_result_in = addr; Val_Rm_in = data;
        for (int c = 0; c <= 2*W+3; c++) begin
            @(negedge clk);
            exp_frz = (c <= 2*W+2);
            if (freeze) frz++;
            checks++;
            if (freeze !== exp_frz) begin
                errors++; $display("FAIL freeze c=%0d got %b exp %b", c, freeze, exp_frz);
            end
            checks++;
            if (WB_Enable !== (wb & ~exp_frz)) begin
                errors++; $display("FAIL wb_enable c=%0d got %b exp %b", c, WB_Enable, wb & ~exp_frz);
            end
            checks++;
            if (ALU_result !== addr || RD !== RD_in || mem_read !== rd) begin
                errors++; $display("FAIL passthru c=%0d got %h/%h/%b exp %h/%h/%b",
                                   c, ALU_result, RD, mem_read, addr, RD_in, rd);
            end
            if (c >= 1 && c <= 2*W+2) begin
                half = (c >= W+2);
                pc   = half ? c - (W+2) : c - 1;
                checks++;
                if (SRAM_ADDR !== {off[18:2], half}) begin
                    errors++; $display("FAIL sram_addr c=%0d got %h exp %h", c, SRAM_ADDR, {off[18:2], half});
                end
                if (wr) begin
                    exp_dq = half ? data[31:16] : data[15:0];
                    checks++;
                    if (SRAM_DQ_oe !== 1'b1 || SRAM_DQ_out !== exp_dq) begin
                        errors++; $display("FAIL wr_bus c=%0d got oe=%b dq=%h exp oe=1 dq=%h", c, SRAM_DQ_oe, SRAM_DQ_out, exp_dq);
                    end
                    checks++;
                    if (SRAM_WE_N !== (pc >= W)) begin
                        errors++; $display("FAIL we_n c=%0d got %b exp %b", c, SRAM_WE_N, pc >= W);
                    end
                    if (!SRAM_WE_N) begin
                        if (half) we_hi++; else we_lo++;
                    end
                end else begin
                    checks++;
                    if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
                        errors++; $display("FAIL rd_bus c=%0d got we_n=%b oe=%b exp 1/0", c, SRAM_WE_N, SRAM_DQ_oe);
                    end
                end
            end else begin
                checks++;
                if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0) begin
                    errors++; $display("FAIL idle_bus c=%0d got we_n=%b oe=%b exp 1/0", c, SRAM_WE_N, SRAM_DQ_oe);
                end
            end
            if (c == 2*W+3) begin
                if (!wr) exp_mem_data = ref_mem[word];
                checks++;
                if (mem_data !== exp_mem_data) begin
                    errors++; $display("FAIL mem_data got %h exp %h", mem_data, exp_mem_data);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (frz != 2*W+3) begin
            errors++; $display("FAIL freeze_len got %0d exp %0d", frz, 2*W+3);
        end
        if (wr) begin
            checks++;
            if (we_lo != W || we_hi != W) begin
                errors++; $display("FAIL we_count got %0d/%0d exp %0d/%0d", we_lo, we_hi, W, W);
            end
            ref_mem[word] = data;
            ref_wr++;
        end else begin
            ref_rd++;
        end
        mem_read_in = 1'b0; mem_write_in = 1'b0; WB_Enable_in = 1'b0;
    endtask

    task automatic alu_op(input logic wb);
        logic [31:0] v;
        v = $urandom();
        WB_Enable_in = wb; mem_read_in = 1'b0; mem_write_in = 1'b0;
        ALU_result_in = v; RD_in = 4'($urandom());
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0 || WB_Enable !== wb) begin
            errors++; $display("FAIL alu_ctrl got frz=%b wb=%b exp 0/%b", freeze, WB_Enable, wb);
        end
        checks++;
        if (SRAM_WE_N !== 1'b1 || ALU_result !== v || RD !== RD_in || mem_data !== exp_mem_data) begin
            errors++; $display("FAIL alu_data got we_n=%b alu=%h md=%h exp 1/%h/%h", SRAM_WE_N, ALU_result, mem_data, v, exp_mem_data);
        end
        @(posedge clk); #1;
        WB_Enable_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_DQ_oe !== 1'b0 || SRAM_DQ_out !== 16'd0 || SRAM_ADDR !== 18'd0) begin
            errors++; $display("FAIL reset_bus got we_n=%b oe=%b dq=%h addr=%h exp 1/0/0/0", SRAM_WE_N, SRAM_DQ_oe, SRAM_DQ_out, SRAM_ADDR);
        end
        checks++;
        if (mem_data !== 32'd0 || freeze !== 1'b0) begin
            errors++; $display("FAIL reset_state got md=%h frz=%b exp 0/0", mem_data, freeze);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0);
        checks++;
        if (exp_mem_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL directed_load got %h exp DEADBEEF", exp_mem_data);
        end
        alu_op(1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = make_addr($urandom_range(0, 15));
            access(1'b0, 1'b1, 1'b0, a, $urandom());
            access(1'b1, 1'b0, 1'b1, a, 32'h0);
        end
    endtask

    task automatic test_random();
        int op, idx;
        int keys[$];
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                idx = $urandom_range(0, 15);
                access(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), make_addr(idx), $urandom());
            end else if (op == 1) begin
                keys.delete();
                foreach (ref_mem[k]) keys.push_back(k);
                idx = keys[$urandom_range(0, keys.size() - 1)];
                access(1'b1, 1'b0, 1'($urandom_range(0, 1)), make_addr(idx), 32'h0);
            end else begin
                alu_op(1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] a, d;
        int          idx;
        idx = $urandom_range(0, 15);
        a = make_addr(idx);
        d = $urandom();
        mem_write_in = 1'b1; Val_Rm_in = d; ALU_result_in = a;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_write_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (SRAM_WE_N !== 1'b1 || freeze !== 1'b0 || mem_data !== 32'd0) begin
            errors++; $display("FAIL mid_reset got we_n=%b frz=%b md=%h exp 1/0/0", SRAM_WE_N, freeze, mem_data);
        end
        @(posedge clk); #1;
        exp_mem_data = 32'd0;
        ref_rd = 0; ref_wr = 0;
        // The low halfword went out before the abort; the high one did not.
        if (ref_mem.exists(idx)) ref_mem[idx][15:0] = d[15:0];
        access(1'b0, 1'b1, 1'b0, a, ~d);
        access(1'b1, 1'b0, 1'b1, a, 32'h0);
        access(1'b1, 1'b0, 1'b1, a, 32'h0);
        access(1'b1, 1'b0, 1'b1, a, 32'h0);
        access(1'b0, 1'b1, 1'b0, make_addr(15 - idx), d);
    endtask

    task automatic test_stats();
`ifdef SRAM_MEM_STAGE_STATS_EN
        @(negedge clk);
        checks++;
        if (rd_count !== 16'(ref_rd) || wr_count !== 16'(ref_wr)) begin
            errors++; $display("FAIL stats got %0d/%0d exp %0d/%0d", rd_count, wr_count, ref_rd, ref_wr);
        end
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
